uart_rx_data_sampling: RTL and testbench

//   Oversampling bit recovery for the UART receiver, directly upstream of parity_check.

---
 rtl/uart_rx_data_sampling.sv | 120 ++++++++++++
 tb/tb_uart_rx_data_sampling.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_data_sampling.sv
// UART receiver oversampling bit recovery. Synchronises the serial line, counts
// oversampling edges per bit, takes three mid-bit samples and majority-votes them.
// Also provides the edge index and the bit-boundary strobe used by the RX controller.
module uart_rx_data_sampling #(
  parameter int unsigned Prescale_Width = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [Prescale_Width-1:0] Prescale,
  input  logic                      dat_samp_en,
  output logic                      Sampled_bit,
  output logic                      Sample_Valid,
  output logic                      Bit_Done,
  output logic [Prescale_Width-1:0] Edge_Cnt,
  output logic                      Prescale_ERR
);

  localparam logic [Prescale_Width-1:0] One  = Prescale_Width'(1);
  localparam logic [Prescale_Width-1:0] P8   = Prescale_Width'(8);
  localparam logic [Prescale_Width-1:0] P16  = Prescale_Width'(16);
  localparam logic [Prescale_Width-1:0] P32  = Prescale_Width'(32);

  logic                      rx_meta_q, rx_s_q;
  logic                      en_q;
  logic [Prescale_Width-1:0] p_q, p_d;
  logic                      err_q, err_d;
  logic [Prescale_Width-1:0] cnt_q, cnt_d;
  logic                      s0_q, s0_d;
  logic                      s1_q, s1_d;
  logic                      bit_q, bit_d;
  logic                      valid_q, valid_d;

  logic                      en_rise;
  logic                      legal;
  logic [Prescale_Width-1:0] half;
  logic [Prescale_Width-1:0] last;

  assign en_rise = dat_samp_en & ~en_q;
  assign legal   = (Prescale == P8) | (Prescale == P16) | (Prescale == P32);
  assign half    = p_q >> 1;
  assign last    = p_q - One;

  // Two-flop synchroniser on the asynchronous serial line; resets to idle-high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state for prescale latch, edge counter, mid-bit samples and the voted bit.
  always_comb begin
    p_d     = p_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    bit_d   = bit_q;
    valid_d = 1'b0;

    // Prescale is only sampled on the enable rising edge; illegal values fall back to 8.
    if (en_rise) begin
      p_d   = legal ? Prescale : P8;
      err_d = ~legal;
    end

    if (dat_samp_en) begin
      cnt_d = (cnt_q == last) ? '0 : cnt_q + One;
      if (cnt_q == half - One) begin
        s0_d = rx_s_q;
      end
      if (cnt_q == half) begin
        s1_d = rx_s_q;
      end
      if (cnt_q == half + One) begin
        bit_d   = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
        valid_d = 1'b1;
      end
    end else begin
      // Abandon any partial bit so a later enable starts clean.
      cnt_d = '0;
      s0_d  = 1'b1;
      s1_d  = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_q    <= 1'b0;
      p_q     <= P8;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      bit_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      en_q    <= dat_samp_en;
      p_q     <= p_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
    end
  end

  assign Sampled_bit  = bit_q;
  assign Sample_Valid = valid_q;
  assign Edge_Cnt     = cnt_q;
  assign Prescale_ERR = err_q;
  assign Bit_Done     = dat_samp_en & (cnt_q == last);

endmodule

// File: tb/tb_uart_rx_data_sampling.sv
// Directed bench for uart_rx_data_sampling: cycle-by-cycle expectations for the
// edge counter, bit-boundary strobe and voted samples across prescale settings.
module tb_uart_rx_data_sampling;

  localparam int W = 6;

  logic         CLK = 1'b0;
  logic         RST;
  logic         RX_IN;
  logic [W-1:0] Prescale;
  logic         dat_samp_en;
  logic         Sampled_bit;
  logic         Sample_Valid;
  logic         Bit_Done;
  logic [W-1:0] Edge_Cnt;
  logic         Prescale_ERR;

  int errors = 0;
  int checks = 0;

  // Value rx_s must hold during enabled cycle k; driven on RX_IN two cycles earlier.
  logic plan [0:199];

  uart_rx_data_sampling #(
    .Prescale_Width(W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .dat_samp_en (dat_samp_en),
    .Sampled_bit (Sampled_bit),
    .Sample_Valid(Sample_Valid),
    .Bit_Done    (Bit_Done),
    .Edge_Cnt    (Edge_Cnt),
    .Prescale_ERR(Prescale_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_plan(input logic v);
    for (int i = 0; i < 200; i++) plan[i] = v;
  endtask

  // Enable and run ncyc cycles, checking every cycle against a period-p_exp model.
  task automatic run_enabled(input int pre, input int p_exp, input int ncyc, input logic err_exp,
                             input int mid_cyc, input int mid_pre);
    int   h;
    int   c;
    logic eb;
    h = p_exp / 2;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      if (k == 0) begin
        Prescale    = W'(pre);
        dat_samp_en = 1'b1;
      end
      if (k == mid_cyc) Prescale = W'(mid_pre);
      RX_IN = plan[k + 2];
      c = k % p_exp;
      checks++;
      if (Edge_Cnt !== W'(c))
        $display("FAIL edge_cnt k=%0d got=%0d exp=%0d", k, Edge_Cnt, c);
      if (Edge_Cnt !== W'(c)) errors++;
      checks++;
      if (Bit_Done !== (c == p_exp - 1)) begin
        $display("FAIL bit_done k=%0d got=%0b exp=%0b", k, Bit_Done, (c == p_exp - 1));
        errors++;
      end
      checks++;
      if (Sample_Valid !== (c == h + 2)) begin
        $display("FAIL sample_valid k=%0d got=%0b exp=%0b", k, Sample_Valid, (c == h + 2));
        errors++;
      end
      if (c == h + 2) begin
        eb = maj(plan[k - 3], plan[k - 2], plan[k - 1]);
        checks++;
        if (Sampled_bit !== eb) begin
          $display("FAIL sampled_bit k=%0d got=%0b exp=%0b", k, Sampled_bit, eb);
          errors++;
        end
      end
      if (k > 0) begin
        checks++;
        if (Prescale_ERR !== err_exp) begin
          $display("FAIL prescale_err k=%0d got=%0b exp=%0b", k, Prescale_ERR, err_exp);
          errors++;
        end
      end
    end
  endtask

  // Drop enable, idle n cycles, then confirm the counter is parked and no strobe.
  task automatic go_idle(input int n);
    tick();
    dat_samp_en = 1'b0;
    RX_IN       = 1'b1;
    repeat (n) tick();
    checks++;
    if (Edge_Cnt !== '0 || Sample_Valid !== 1'b0) begin
      $display("FAIL idle got cnt=%0d valid=%0b exp cnt=0 valid=0", Edge_Cnt, Sample_Valid);
      errors++;
    end
  endtask

  task automatic test_reset();
    RST         = 1'b1;
    RX_IN       = 1'b1;
    Prescale    = W'(8);
    dat_samp_en = 1'b0;
    #2 RST = 1'b0;
    tick();
    tick();
    checks++;
    if ({Sampled_bit, Sample_Valid, Bit_Done, Edge_Cnt, Prescale_ERR} !== {3'b100, 6'd0, 1'b0}) begin
      $display("FAIL reset got bit=%0b valid=%0b done=%0b cnt=%0d err=%0b exp 1 0 0 0 0",
               Sampled_bit, Sample_Valid, Bit_Done, Edge_Cnt, Prescale_ERR);
      errors++;
    end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_p8_zero();
    set_plan(1'b0);
    run_enabled(8, 8, 8, 1'b0, -1, 0);
    go_idle(3);
    checks++;
    if (Sampled_bit !== 1'b0) begin
      $display("FAIL hold_while_disabled got=%0b exp=0", Sampled_bit);
      errors++;
    end
  endtask

  task automatic test_glitch_vote();
    set_plan(1'b1);
    plan[8]  = 1'b0;
    plan[9]  = 1'b0;
    plan[24] = 1'b0;
    run_enabled(16, 16, 32, 1'b0, -1, 0);
    go_idle(2);
  endtask

  task automatic test_back_to_back();
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 200; i++) plan[i] = (i < 128) ? pat[i / 32] : 1'b1;
    run_enabled(32, 32, 128, 1'b0, -1, 0);
    go_idle(2);
  endtask

  task automatic test_prescale_err();
    set_plan(1'b0);
    run_enabled(12, 8, 16, 1'b1, -1, 0);
    go_idle(2);
    run_enabled(16, 16, 16, 1'b0, -1, 0);
    go_idle(2);
  endtask

  task automatic test_prescale_change();
    set_plan(1'b0);
    run_enabled(8, 8, 16, 1'b0, 3, 16);
    go_idle(2);
    run_enabled(16, 16, 16, 1'b0, -1, 0);
    go_idle(2);
  endtask

  task automatic test_reset_mid();
    set_plan(1'b0);
    run_enabled(12, 8, 6, 1'b1, -1, 0);
    checks++;
    if (Sampled_bit !== 1'b0) begin
      $display("FAIL pre_reset_bit got=%0b exp=0", Sampled_bit);
      errors++;
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({Sampled_bit, Sample_Valid, Bit_Done, Edge_Cnt, Prescale_ERR} !== {3'b100, 6'd0, 1'b0}) begin
      $display("FAIL reset_mid got bit=%0b valid=%0b done=%0b cnt=%0d err=%0b exp 1 0 0 0 0",
               Sampled_bit, Sample_Valid, Bit_Done, Edge_Cnt, Prescale_ERR);
      errors++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Sample_Valid !== 1'b0 || Edge_Cnt !== '0) begin
        $display("FAIL reset_hold i=%0d got valid=%0b cnt=%0d exp 0 0", i, Sample_Valid, Edge_Cnt);
        errors++;
      end
    end
    dat_samp_en = 1'b0;
    tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic test_disable_mid();
    set_plan(1'b0);
    run_enabled(8, 8, 4, 1'b0, -1, 0);
    tick();
    dat_samp_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (Sample_Valid !== 1'b0 || Edge_Cnt !== '0 || Sampled_bit !== 1'b1) begin
        $display("FAIL disable_mid i=%0d got valid=%0b cnt=%0d bit=%0b exp 0 0 1",
                 i, Sample_Valid, Edge_Cnt, Sampled_bit);
        errors++;
      end
    end
  endtask

  task automatic test_disable_tail();
    set_plan(1'b0);
    run_enabled(8, 8, 6, 1'b0, -1, 0);
    tick();
    dat_samp_en = 1'b0;
    checks++;
    if (Sample_Valid !== 1'b1 || Sampled_bit !== 1'b0 || Bit_Done !== 1'b0) begin
      $display("FAIL tail_strobe got valid=%0b bit=%0b done=%0b exp 1 0 0",
               Sample_Valid, Sampled_bit, Bit_Done);
      errors++;
    end
    tick();
    checks++;
    if (Sample_Valid !== 1'b0 || Edge_Cnt !== '0) begin
      $display("FAIL tail_end got valid=%0b cnt=%0d exp 0 0", Sample_Valid, Edge_Cnt);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_p8_zero();
    test_glitch_vote();
    test_back_to_back();
    test_prescale_err();
    test_prescale_change();
    test_reset_mid();
    test_disable_mid();
    test_disable_tail();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
